// File: rtl/cnn_pkg.sv
// Shared types for the convolution datapath: Q5.10 pixels and the KxK window.
// The window producer and the dot-product block agree on window_t.
package cnn_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned FRAC_W = 10;
   localparam int unsigned K      = 5;

   typedef logic signed [DATA_W-1:0] pixel_t;
   typedef pixel_t window_t [0:K*K-1];

   // Row-major flat index of window element (r, c).
   function automatic int unsigned win_idx(input int unsigned r, input int unsigned c,
                                           input int unsigned k);
      return r * k + c;
   endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-row delay line advanced by the accepted-pixel strobe.
// A depth of zero degenerates to a wire (image exactly one kernel wide).
module line_buffer #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 27
) (
   input  logic                     clk,
   input  logic                     shift,
   input  logic signed [DATA_W-1:0] din,
   output logic signed [DATA_W-1:0] dout
);

   if (DEPTH == 0) begin : g_wire
      assign dout = din;
   end else begin : g_delay
      logic signed [DATA_W-1:0] sr_q [DEPTH];

      always_ff @(posedge clk) begin
         if (shift) begin
            sr_q[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
               sr_q[i] <= sr_q[i-1];
            end
         end
      end

      assign dout = sr_q[DEPTH-1];
   end

endmodule

// File: rtl/conv_window_gen.sv
// Raster-stream to KxK sliding-window generator (stride 1, no padding).
// A KxK register array plus K-1 line buffers keeps every window column aligned.
module conv_window_gen #(
   parameter int unsigned DATA_W = cnn_pkg::DATA_W,
   parameter int unsigned K      = cnn_pkg::K,
   parameter int unsigned IMG_W  = 32,
   parameter int unsigned IMG_H  = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_pixel,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_window [0:K*K-1],
   output logic                     out_last,
   output logic                     frame_done
);

   import cnn_pkg::*;

   localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          out_valid_q, out_valid_d;
   logic          out_last_q, out_last_d;
   logic          frame_done_q, frame_done_d;
   logic          shift, col_end, row_end, win_done;

   logic signed [DATA_W-1:0] win_q  [K][K];
   logic signed [DATA_W-1:0] col_in [K];
   logic signed [DATA_W-1:0] lb_out [K-1];

   assign in_ready = !out_valid_q || out_ready;
   // clear wins over a concurrent handshake, so that pixel never shifts in
   assign shift    = in_valid && in_ready && !clear;
   assign col_end  = (col_q == CW'(IMG_W - 1));
   assign row_end  = (row_q == RW'(IMG_H - 1));
   assign win_done = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      frame_done_d = 1'b0;
      if (clear) begin
         col_d       = '0;
         row_d       = '0;
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end else begin
         if (out_valid_q && out_ready) begin
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
            frame_done_d = out_last_q;
         end
         if (shift) begin
            col_d = col_end ? '0 : col_q + CW'(1);
            if (col_end) begin
               row_d = row_end ? '0 : row_q + RW'(1);
            end
            if (win_done) begin
               out_valid_d = 1'b1;
               out_last_d  = col_end && row_end;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q        <= '0;
         row_q        <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Row r's evicted column, delayed one image row, becomes row r-1's newest column.
   for (genvar r = 0; r < int'(K) - 1; r++) begin : g_lb
      line_buffer #(
         .DATA_W (DATA_W),
         .DEPTH  (IMG_W - K)
      ) u_line_buffer (
         .clk   (clk),
         .shift (shift),
         .din   (win_q[r+1][0]),
         .dout  (lb_out[r])
      );
   end

   always_comb begin
      for (int r = 0; r < int'(K) - 1; r++) begin
         col_in[r] = lb_out[r];
      end
      col_in[K-1] = in_pixel;
   end

   always_ff @(posedge clk) begin
      if (shift) begin
         for (int r = 0; r < int'(K); r++) begin
            for (int c = 0; c < int'(K) - 1; c++) begin
               win_q[r][c] <= win_q[r][c+1];
            end
            win_q[r][K-1] <= col_in[r];
         end
      end
   end

   always_comb begin
      for (int r = 0; r < int'(K); r++) begin
         for (int c = 0; c < int'(K); c++) begin
            out_window[win_idx(r, c, K)] = win_q[r][c];
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign out_last   = out_last_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on an 8x8 image with a 5x5 kernel.
// Windows are captured by the streaming task and checked inline by each test.
module tb_conv_window_gen;
   import cnn_pkg::*;

   localparam int IW = 8;
   localparam int IH = 8;
   localparam int NW = (IW - 5 + 1) * (IH - 5 + 1);

   logic    clk = 1'b0;
   logic    rst_n, clear, in_valid, in_ready, out_valid, out_ready, out_last, frame_done;
   pixel_t  in_pixel;
   window_t out_window;

   int      nvec = 0;
   int      nerr = 0;

   window_t rec  [0:63];
   bit      rlast[0:63];
   int      rcyc [0:63];
   int      nwin, ndone;
   bit      stall_ok, stall_inready, timed_out;

   conv_window_gen #(
      .DATA_W (16),
      .K      (5),
      .IMG_W  (IW),
      .IMG_H  (IH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_pixel   (in_pixel),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_window (out_window),
      .out_last   (out_last),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   function automatic pixel_t pix(input int mode, input int idx);
      int r, c;
      r = idx / IW;
      c = idx % IW;
      case (mode)
         0:       return pixel_t'((r * IW + c) << 10);
         1:       return 16'h0400;
         default: return 16'hB000;
      endcase
   endfunction

   function automatic pixel_t exp_elem(input int w, input int e);
      int wr, wc;
      wr = w / (IW - 4);
      wc = w % (IW - 4);
      return pixel_t'((((wr + e / 5) * IW) + wc + e % 5) << 10);
   endfunction

   // Streams npix pixels from frame index start; captures every window handshake.
   task automatic stream(input int mode, input int start, input int npix, input int stall_cyc);
      int      sent = 0, tail = 0, cyc = 0, stall_left;
      bit      stalled = 0;
      window_t held;
      nwin = 0; ndone = 0; stall_ok = 1; stall_inready = 0; timed_out = 0;
      stall_left = stall_cyc;
      while ((sent < npix || out_valid || tail < 3) && cyc < 600) begin
         @(posedge clk); #1; cyc++;
         if (frame_done) ndone++;
         if (out_valid && stall_left > 0) begin
            if (!stalled) begin
               stalled = 1;
               held = out_window;
            end else begin
               for (int e = 0; e < 25; e++) if (out_window[e] !== held[e]) stall_ok = 0;
            end
            out_ready = 1'b0;
            stall_left--;
         end else begin
            out_ready = 1'b1;
         end
         in_valid = (sent < npix);
         in_pixel = pix(mode, start + sent);
         #1;
         if (!out_ready && in_ready) stall_inready = 1;
         if (out_valid && out_ready) begin
            rec[nwin]   = out_window;
            rlast[nwin] = out_last;
            rcyc[nwin]  = cyc;
            nwin++;
         end
         if (in_valid && in_ready) sent++;
         if (sent >= npix && !out_valid) tail++;
      end
      if (cyc >= 600) timed_out = 1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic do_clear(input bit with_pixel);
      @(posedge clk); #1;
      clear     = 1'b1;
      in_valid  = with_pixel;
      in_pixel  = 16'h7FFF;
      out_ready = 1'b1;
      @(posedge clk); #1;
      clear    = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_pixel = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      nvec++; if (frame_done !== 1'b0) begin nerr++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
      nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      stream(0, 0, 36, 0);
      nvec++; if (nwin !== 0) begin nerr++; $display("FAIL reset_no_early_window got %0d want 0", nwin); end
      stream(0, 36, 1, 0);
      nvec++;
      if (nwin !== 1 || rec[0][0] !== exp_elem(0, 0) || rec[0][24] !== exp_elem(0, 24)) begin
         nerr++;
         $display("FAIL reset_first_window got n=%0d e0=%h e24=%h want n=1 e0=%h e24=%h",
                  nwin, rec[0][0], rec[0][24], exp_elem(0, 0), exp_elem(0, 24));
      end
   endtask

   task automatic test_indexed_frame();
      bit last_bad;
      do_clear(1'b0);
      stream(0, 0, 64, 0);
      nvec++; if (timed_out || nwin !== NW) begin nerr++; $display("FAIL idx_count got %0d want %0d", nwin, NW); end
      for (int w = 0; w < NW && w < nwin; w++) begin
         nvec++;
         for (int e = 0; e < 25; e++) begin
            if (rec[w][e] !== exp_elem(w, e)) begin
               nerr++;
               $display("FAIL idx_window%0d elem%0d got %h want %h", w, e, rec[w][e], exp_elem(w, e));
               break;
            end
         end
      end
      nvec++; if (rec[NW-1][0] !== pixel_t'(27 << 10)) begin nerr++; $display("FAIL idx_last_e0 got %h want %h", rec[NW-1][0], pixel_t'(27 << 10)); end
      nvec++; if (rlast[NW-1] !== 1'b1) begin nerr++; $display("FAIL idx_out_last got %b want 1", rlast[NW-1]); end
      last_bad = 0;
      for (int w = 0; w < NW - 1; w++) if (rlast[w]) last_bad = 1;
      nvec++; if (last_bad !== 1'b0) begin nerr++; $display("FAIL idx_early_last got %b want 0", last_bad); end
      nvec++; if (ndone !== 1) begin nerr++; $display("FAIL idx_frame_done got %0d pulses want 1", ndone); end
   endtask

   task automatic test_constant();
      int bad;
      for (int m = 1; m <= 2; m++) begin
         bad = 0;
         stream(m, 0, 64, 0);
         for (int w = 0; w < nwin; w++)
            for (int e = 0; e < 25; e++) if (rec[w][e] !== pix(m, 0)) bad++;
         nvec++; if (nwin !== NW) begin nerr++; $display("FAIL const%0d_count got %0d want %0d", m, nwin, NW); end
         nvec++; if (bad !== 0) begin nerr++; $display("FAIL const%0d_value got %0d bad elems want 0 (%h)", m, bad, pix(m, 0)); end
      end
      nvec++; if (rec[NW-1][12][15] !== 1'b1) begin nerr++; $display("FAIL const_sign got %b want 1", rec[NW-1][12][15]); end
   endtask

   task automatic test_backpressure();
      int bad = 0;
      do_clear(1'b0);
      stream(0, 0, 64, 10);
      nvec++; if (stall_ok !== 1'b1) begin nerr++; $display("FAIL bp_window_stable got %b want 1", stall_ok); end
      nvec++; if (stall_inready !== 1'b0) begin nerr++; $display("FAIL bp_in_ready_low got %b want 0", stall_inready); end
      nvec++; if (nwin !== NW) begin nerr++; $display("FAIL bp_count got %0d want %0d", nwin, NW); end
      for (int w = 0; w < nwin; w++)
         for (int e = 0; e < 25; e++) if (rec[w][e] !== exp_elem(w, e)) bad++;
      nvec++; if (bad !== 0) begin nerr++; $display("FAIL bp_sequence got %0d bad elems want 0", bad); end
      nvec++; if (ndone !== 1) begin nerr++; $display("FAIL bp_frame_done got %0d want 1", ndone); end
   endtask

   task automatic test_back_to_back();
      do_clear(1'b0);
      stream(0, 0, 64, 0);
      nvec++; if (rcyc[1] - rcyc[0] !== 1) begin nerr++; $display("FAIL b2b_gap01 got %0d want 1", rcyc[1] - rcyc[0]); end
      nvec++; if (rcyc[3] - rcyc[0] !== 3) begin nerr++; $display("FAIL b2b_gap03 got %0d want 3", rcyc[3] - rcyc[0]); end
      nvec++; if (rcyc[4] - rcyc[3] !== 5) begin nerr++; $display("FAIL b2b_rowwrap got %0d want 5", rcyc[4] - rcyc[3]); end
   endtask

   task automatic test_abort();
      int bad = 0;
      do_clear(1'b0);
      stream(0, 0, 20, 0);
      do_clear(1'b1);
      nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL abort_out_valid got %b want 0", out_valid); end
      stream(0, 0, 64, 0);
      nvec++; if (nwin !== NW) begin nerr++; $display("FAIL abort_count got %0d want %0d", nwin, NW); end
      for (int e = 0; e < 25; e++) if (rec[0][e] !== exp_elem(0, e)) bad++;
      nvec++; if (bad !== 0) begin nerr++; $display("FAIL abort_first_window got %0d bad elems want 0", bad); end
      nvec++; if (ndone !== 1) begin nerr++; $display("FAIL abort_frame_done got %0d want 1", ndone); end
   endtask

   initial begin
      test_reset();
      test_indexed_frame();
      test_constant();
      test_backpressure();
      test_back_to_back();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
